fractal_stream_buffer: RTL

Elastic output stage between `fractal_colorizer` and the AXI4-Stream master port. It is the next-generation replacement for the direct colorizer-to-`m_axis` connection, which ignores `m_axis_tready`. The block absorbs pixels from the push-only pixel pipeline into a parametrised FWFT FIFO and presents a fully AXI4-Stream-compliant master with backpressure. It raises an early `stall_out` so the pipeline can throttle, and on overflow it drops pixels until the next frame start, so that a corrupt frame is never emitted mid-line.

---
 rtl/fractal_stream_buffer_if.sv | 23 ++
 rtl/fractal_stream_buffer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fractal_stream_buffer_if.sv
// AXI4-Stream pixel bus between the stream buffer and its downstream consumer.
interface fractal_stream_buffer_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic [STRB_W-1:0]     tstrb;
  logic                  tuser;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tvalid, tdata, tstrb, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/fractal_stream_buffer.sv
// Elastic FWFT buffer turning the push-only colorizer output into an AXI4-Stream
// master with backpressure; on overflow it drops pixels until the next frame start.
module fractal_stream_buffer #(
  parameter int unsigned DATA_WIDTH         = 24,
  parameter int unsigned DEPTH              = 64,
  parameter int unsigned ALMOST_FULL_MARGIN = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    frame_start_in,
  input  logic                    line_end_in,
  input  logic                    data_enable_in,
  output logic                    stall_out,
  fractal_stream_buffer_if.master m_axis,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    dropping,
  output logic [15:0]             overflow_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 2;
  localparam int unsigned STRB_W  = DATA_WIDTH / 8;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] entry_in;
  logic               valid;
  logic               pop;
  logic               space;
  logic               push;
  logic               ovf_inc;

  assign valid    = (level != '0);
  assign pop      = valid && m_axis.tready;
  // A full FIFO still has room when the head leaves on the same edge.
  assign space    = (level < LVL_W'(DEPTH)) || pop;
  assign entry_in = {frame_start_in, line_end_in, data_in};
  assign head     = mem[rd_ptr];

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ST_PASS;
    end else begin
      state <= state_nxt;
    end
  end

  // Accept/drop decision; DROP only recovers on a frame start that fits
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    ovf_inc   = 1'b0;
    case (state)
      ST_PASS: begin
        if (data_enable_in) begin
          if (space) begin
            push = 1'b1;
          end else begin
            ovf_inc   = 1'b1;
            state_nxt = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (data_enable_in && frame_start_in && space) begin
          push      = 1'b1;
          state_nxt = ST_PASS;
        end
      end
      default: state_nxt = ST_PASS;
    endcase
  end

  // Pointers, occupancy and overflow statistics
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      overflow_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (ovf_inc && (overflow_count != 16'hFFFF)) begin
        overflow_count <= overflow_count + 16'd1;
      end
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  assign stall_out = (LVL_W'(DEPTH) - level) <= LVL_W'(ALMOST_FULL_MARGIN);
  assign dropping  = (state == ST_DROP);

  // Payload is zeroed while idle so the bus never shows stale entries
  assign m_axis.tvalid = valid;
  assign m_axis.tdata  = valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis.tuser  = valid ? head[ENTRY_W-1]      : 1'b0;
  assign m_axis.tlast  = valid ? head[ENTRY_W-2]      : 1'b0;
  assign m_axis.tstrb  = {STRB_W{1'b1}};

endmodule
